// File: rtl/cnn_layer_sequencer.sv
// Run-time programmable layer sequencer for the CNN accelerator controller.
// "do" is a reserved word, so the output-channel dimension port is named d_o.
module cnn_layer_sequencer #(
    parameter int MAX_LAYERS = 8,
    parameter int LIDX_W     = 4,
    parameter int ADDR_W     = 14,
    parameter int FS_W       = 8,
    parameter int TMO_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cnn_start,
    input  logic              cont,
    input  logic              abort,
    input  logic [LIDX_W:0]   num_layers,
    input  logic [TMO_W-1:0]  tmo_limit,
    input  logic              cfg_we,
    input  logic [LIDX_W-1:0] cfg_layer,
    input  logic [3:0]        cfg_field,
    input  logic [ADDR_W-1:0] cfg_data,
    input  logic              picture_finish,
    output logic              start,
    output logic [ADDR_W-1:0] d_o,
    output logic [ADDR_W-1:0] di,
    output logic [ADDR_W-1:0] dr,
    output logic [ADDR_W-1:0] dc,
    output logic [ADDR_W-1:0] dkc,
    output logic [ADDR_W-1:0] dkr,
    output logic [ADDR_W-1:0] di_out,
    output logic [ADDR_W-1:0] dr_out,
    output logic [ADDR_W-1:0] dc_out,
    output logic [ADDR_W-1:0] inaddr,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] outaddr,
    output logic [FS_W-1:0]   filter_size,
    output logic [LIDX_W-1:0] layer_idx,
    output logic              busy,
    output logic              cnn_finish,
    output logic              err,
    output logic              cfg_err
);

    localparam int NF = 13;
    localparam int TW = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;
    localparam logic [LIDX_W:0]   MAXL    = (LIDX_W+1)'(MAX_LAYERS);
    localparam logic [LIDX_W:0]   NL_ONE  = {{LIDX_W{1'b0}}, 1'b1};
    localparam logic [LIDX_W-1:0] IDX_ONE = {{(LIDX_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0]  TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

    typedef enum logic [7:0] {
        S_IDLE  = 8'h00,
        S_LOAD  = 8'h01,
        S_START = 8'h02,
        S_RUN   = 8'h03,
        S_DONE  = 8'h04,
        S_ERR   = 8'h05
    } state_t;

    state_t state, next_state;

    logic [ADDR_W-1:0] tbl    [MAX_LAYERS][NF];
    logic [ADDR_W-1:0] desc_q [NF];
    logic              pf_d;
    logic              evt;
    logic [LIDX_W-1:0] idx;
    logic [LIDX_W:0]   nl;
    logic [TMO_W-1:0]  wdog;
    logic [TW-1:0]     tidx;
    logic              idle_like;
    logic              nl_ok;
    logic              last_layer;
    logic              wdog_exp;
    logic              cfg_reject;
    logic              cfg_ok;
    logic              start_bad;

    assign evt        = pf_d & ~picture_finish;
    assign tidx       = idx[TW-1:0];
    assign idle_like  = (state == S_IDLE) || (state == S_ERR);
    assign nl_ok      = (num_layers != '0) && (num_layers <= MAXL);
    assign last_layer = ({1'b0, idx} == (nl - NL_ONE));
    assign wdog_exp   = (tmo_limit != '0) && (wdog == (tmo_limit - TMO_ONE));
    assign cfg_reject = busy || ({1'b0, cfg_layer} >= MAXL) || (cfg_field >= 4'd13);
    assign cfg_ok     = cfg_we && !cfg_reject;
    assign start_bad  = idle_like && cnn_start && !nl_ok;

    assign d_o         = desc_q[0];
    assign di          = desc_q[1];
    assign dr          = desc_q[2];
    assign dc          = desc_q[3];
    assign dkc         = desc_q[4];
    assign dkr         = desc_q[5];
    assign filter_size = desc_q[6][FS_W-1:0];
    assign di_out      = desc_q[7];
    assign dr_out      = desc_q[8];
    assign dc_out      = desc_q[9];
    assign inaddr      = desc_q[10];
    assign waddr       = desc_q[11];
    assign outaddr     = desc_q[12];
    assign layer_idx   = idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Abort beats a completion event, which beats watchdog expiry.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_ERR: begin
                    if (cnn_start) begin
                        next_state = nl_ok ? S_LOAD : S_IDLE;
                    end
                end
                S_LOAD:  next_state = S_START;
                S_START: next_state = S_RUN;
                S_RUN: begin
                    if (evt) begin
                        next_state = last_layer ? S_DONE : S_LOAD;
                    end else if (wdog_exp) begin
                        next_state = S_ERR;
                    end
                end
                S_DONE:  next_state = cont ? S_LOAD : S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        start      = (state == S_START);
        cnn_finish = (state == S_DONE);
        busy       = !((state == S_IDLE) || (state == S_ERR));
    end

    // The descriptor table has no reset; entries are meaningful only once written.
    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            tbl[cfg_layer[TW-1:0]][cfg_field] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pf_d    <= 1'b0;
            idx     <= '0;
            nl      <= '0;
            wdog    <= '0;
            err     <= 1'b0;
            cfg_err <= 1'b0;
            for (int f = 0; f < NF; f++) begin
                desc_q[f] <= '0;
            end
        end else begin
            pf_d    <= picture_finish;
            cfg_err <= (cfg_we && cfg_reject) || start_bad;

            if (idle_like && cnn_start && nl_ok && !abort) begin
                nl <= num_layers;
            end

            if (state == S_START) begin
                wdog <= '0;
            end else if (state == S_RUN) begin
                wdog <= wdog + TMO_ONE;
            end

            if ((state == S_RUN) && (next_state == S_ERR)) begin
                err <= 1'b1;
            end else if ((state == S_ERR) && cnn_start && !abort) begin
                err <= 1'b0;
            end

            if ((next_state == S_IDLE) || (next_state == S_ERR)) begin
                idx <= '0;
            end else if ((state == S_RUN) && evt) begin
                idx <= last_layer ? '0 : (idx + IDX_ONE);
            end

            if ((next_state == S_IDLE) || (next_state == S_ERR)) begin
                for (int f = 0; f < NF; f++) begin
                    desc_q[f] <= '0;
                end
            end else if (state == S_LOAD) begin
                for (int f = 0; f < NF; f++) begin
                    desc_q[f] <= tbl[tidx][f];
                end
            end
        end
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: directed schedule plus randomized descriptor
// tables and layer counts, checked against a cycle-level reference of the protocol.
module tb_cnn_layer_sequencer;

    localparam int MAX_LAYERS = 8;
    localparam int LIDX_W     = 4;
    localparam int ADDR_W     = 14;
    localparam int FS_W       = 8;
    localparam int TMO_W      = 20;
    localparam int NF         = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic              cnn_start;
    logic              cont;
    logic              abort;
    logic [LIDX_W:0]   num_layers;
    logic [TMO_W-1:0]  tmo_limit;
    logic              cfg_we;
    logic [LIDX_W-1:0] cfg_layer;
    logic [3:0]        cfg_field;
    logic [ADDR_W-1:0] cfg_data;
    logic              picture_finish;
    logic              start;
    logic [ADDR_W-1:0] d_o, di, dr, dc, dkc, dkr, di_out, dr_out, dc_out;
    logic [ADDR_W-1:0] inaddr, waddr, outaddr;
    logic [FS_W-1:0]   filter_size;
    logic [LIDX_W-1:0] layer_idx;
    logic              busy;
    logic              cnn_finish;
    logic              err;
    logic              cfg_err;

    int vectors     = 0;
    int miscompares = 0;
    int fin_cnt     = 0;

    logic [ADDR_W-1:0] ref_tbl  [MAX_LAYERS][NF];
    logic [ADDR_W-1:0] obs_desc [NF];

    int sched [4][NF] = '{
        '{4,  1,  28, 28, 4, 4, 4, 4,  13, 13, 2,    806,  1001},
        '{4,  4,  13, 13, 5, 5, 5, 4,  5,  5,  1001, 2001, 2501},
        '{40, 4,  5,  5,  5, 5, 5, 40, 1,  1,  2501, 2601, 6601},
        '{10, 40, 1,  1,  1, 1, 1, 10, 1,  1,  6601, 6701, 7101}
    };

    cnn_layer_sequencer #(
        .MAX_LAYERS(MAX_LAYERS), .LIDX_W(LIDX_W), .ADDR_W(ADDR_W),
        .FS_W(FS_W), .TMO_W(TMO_W)
    ) dut (
        .clk(clk), .rst(rst), .cnn_start(cnn_start), .cont(cont), .abort(abort),
        .num_layers(num_layers), .tmo_limit(tmo_limit), .cfg_we(cfg_we),
        .cfg_layer(cfg_layer), .cfg_field(cfg_field), .cfg_data(cfg_data),
        .picture_finish(picture_finish), .start(start), .d_o(d_o), .di(di),
        .dr(dr), .dc(dc), .dkc(dkc), .dkr(dkr), .di_out(di_out), .dr_out(dr_out),
        .dc_out(dc_out), .inaddr(inaddr), .waddr(waddr), .outaddr(outaddr),
        .filter_size(filter_size), .layer_idx(layer_idx), .busy(busy),
        .cnn_finish(cnn_finish), .err(err), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        obs_desc[0]  = d_o;
        obs_desc[1]  = di;
        obs_desc[2]  = dr;
        obs_desc[3]  = dc;
        obs_desc[4]  = dkc;
        obs_desc[5]  = dkr;
        obs_desc[6]  = {{(ADDR_W-FS_W){1'b0}}, filter_size};
        obs_desc[7]  = di_out;
        obs_desc[8]  = dr_out;
        obs_desc[9]  = dc_out;
        obs_desc[10] = inaddr;
        obs_desc[11] = waddr;
        obs_desc[12] = outaddr;
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && cnn_finish === 1'b1) fin_cnt = fin_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkDesc(input string tag, input int l);
        for (int f = 0; f < NF; f++)
            checkOutput($sformatf("%s.L%0d.f%0d", tag, l, f), 32'(obs_desc[f]), 32'(ref_tbl[l][f]));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".busy"}, 32'(busy), 0);
        checkOutput({tag, ".start"}, 32'(start), 0);
        checkOutput({tag, ".layer_idx"}, 32'(layer_idx), 0);
        for (int f = 0; f < NF; f++)
            checkOutput($sformatf("%s.zero.f%0d", tag, f), 32'(obs_desc[f]), 0);
    endtask

    // Descriptor write; the model decides acceptance from the write rules alone.
    task automatic applyStimulus(input int layer, input int field, input logic [ADDR_W-1:0] data,
                                 input bit model_busy);
        bit reject;
        reject    = model_busy || (layer >= MAX_LAYERS) || (field >= NF);
        cfg_we    = 1'b1;
        cfg_layer = LIDX_W'(layer);
        cfg_field = 4'(field);
        cfg_data  = data;
        tick();
        cfg_we = 1'b0;
        checkOutput($sformatf("cfg_err.L%0d.f%0d", layer, field), 32'(cfg_err), 32'(reject));
        if (!reject)
            ref_tbl[layer][field] = (field == 6) ? (data & ADDR_W'((1 << FS_W) - 1)) : data;
    endtask

    // Ends with the layer-0 start pulse visible.
    task automatic startRun(input int n);
        num_layers = (LIDX_W+1)'(n);
        cnn_start  = 1'b1;
        tick();
        cnn_start = 1'b0;
        checkOutput("load.busy", 32'(busy), 1);
        checkOutput("load.start", 32'(start), 0);
        tick();
    endtask

    // Entered with layer l's start visible; drops picture_finish gap cycles after it.
    task automatic runLayer(input int l, input int n, input int gap);
        checkOutput($sformatf("start.L%0d", l), 32'(start), 1);
        checkOutput($sformatf("layer_idx.L%0d", l), 32'(layer_idx), 32'(l));
        checkDesc("desc", l);
        picture_finish = 1'b1;
        tick();
        checkOutput("start_off", 32'(start), 0);
        checkOutput("run.busy", 32'(busy), 1);
        repeat (gap - 1) tick();
        picture_finish = 1'b0;
        tick();
        picture_finish = 1'b1;
        if (l < n - 1) begin
            checkOutput("gap.finish", 32'(cnn_finish), 0);
            checkOutput("gap.start", 32'(start), 0);
            tick();
        end else begin
            checkOutput("cnn_finish", 32'(cnn_finish), 1);
        end
    endtask

    task automatic runImage(input int n, input int gap, input bit cont_val);
        for (int l = 0; l < n; l++) runLayer(l, n, gap);
        cont = cont_val;
        tick();
        cont = 1'b0;
        checkOutput("post.finish", 32'(cnn_finish), 0);
        if (cont_val) begin
            checkOutput("cont.busy", 32'(busy), 1);
            checkOutput("cont.start", 32'(start), 0);
            tick();
        end else begin
            checkIdle("done_idle");
        end
    endtask

    initial begin
        int f0, n, gap;
        logic [ADDR_W-1:0] rd;

        rst = 1'b0; cnn_start = 0; cont = 0; abort = 0; num_layers = '0; tmo_limit = '0;
        cfg_we = 0; cfg_layer = '0; cfg_field = '0; cfg_data = '0; picture_finish = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkIdle("reset");
        checkOutput("reset.err", 32'(err), 0);
        checkOutput("reset.cfg_err", 32'(cfg_err), 0);
        checkOutput("reset.finish", 32'(cnn_finish), 0);
        rst = 1'b1;
        tick();

        $display("[TB] four-layer schedule");
        for (int l = 0; l < 4; l++)
            for (int f = 0; f < NF; f++) applyStimulus(l, f, ADDR_W'(sched[l][f]), 0);
        f0 = fin_cnt;
        startRun(4);
        runImage(4, 50, 0);
        checkOutput("sched.finish_count", 32'(fin_cnt - f0), 1);

        $display("[TB] continuous mode");
        f0 = fin_cnt;
        startRun(2);
        runImage(2, 20, 1);
        runImage(2, 20, 0);
        checkOutput("cont.finish_count", 32'(fin_cnt - f0), 2);

        $display("[TB] abort during layer 1");
        f0 = fin_cnt;
        startRun(2);
        runLayer(0, 2, 20);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkIdle("abort");
        checkOutput("abort.err", 32'(err), 0);
        repeat (4) tick();
        checkOutput("abort.finish_count", 32'(fin_cnt - f0), 0);
        startRun(2);
        runImage(2, 15, 0);

        $display("[TB] watchdog");
        picture_finish = 1'b0;
        tmo_limit = 20'd100;
        tick();
        startRun(1);
        checkOutput("wd.start", 32'(start), 1);
        repeat (100) tick();
        checkOutput("wd.pre.busy", 32'(busy), 1);
        checkOutput("wd.pre.err", 32'(err), 0);
        tick();
        checkOutput("wd.busy", 32'(busy), 0);
        checkOutput("wd.err", 32'(err), 1);
        checkIdle("wd");
        num_layers = 1;
        cnn_start  = 1'b1;
        tick();
        cnn_start = 1'b0;
        checkOutput("wd.clear.err", 32'(err), 0);
        checkOutput("wd.clear.busy", 32'(busy), 1);
        tick();
        runImage(1, 50, 0);

        $display("[TB] rejected writes and starts");
        tmo_limit = '0;
        startRun(1);
        applyStimulus(0, 0, 14'h3abc, 1);
        picture_finish = 1'b0;
        tick();
        picture_finish = 1'b1;
        checkOutput("rej.finish", 32'(cnn_finish), 1);
        tick();
        checkIdle("rej.idle");
        applyStimulus(0, 14, 14'h1234, 0);
        applyStimulus(8, 0, 14'h0777, 0);
        num_layers = 0;
        cnn_start = 1'b1;
        tick();
        cnn_start = 1'b0;
        checkOutput("nl0.cfg_err", 32'(cfg_err), 1);
        checkOutput("nl0.busy", 32'(busy), 0);
        num_layers = 9;
        cnn_start = 1'b1;
        tick();
        cnn_start = 1'b0;
        checkOutput("nl9.cfg_err", 32'(cfg_err), 1);
        checkOutput("nl9.busy", 32'(busy), 0);
        tick();
        checkOutput("cfg_err.pulse", 32'(cfg_err), 0);
        startRun(1);
        runImage(1, 10, 0);

        $display("[TB] event and abort together");
        f0 = fin_cnt;
        startRun(2);
        repeat (10) tick();
        picture_finish = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        picture_finish = 1'b1;
        checkIdle("evt_abort");
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("evt_abort.nostart%0d", i), 32'(start), 0);
        end
        checkOutput("evt_abort.finish_count", 32'(fin_cnt - f0), 0);

        $display("[TB] randomized tables");
        for (int l = 0; l < MAX_LAYERS; l++)
            for (int f = 0; f < NF; f++) begin
                rd = ADDR_W'($urandom);
                applyStimulus(l, f, rd, 0);
            end
        for (int it = 0; it < 5; it++) begin
            n   = int'($urandom_range(1, MAX_LAYERS));
            gap = int'($urandom_range(3, 30));
            tmo_limit = ($urandom_range(0, 1) == 0) ? '0 : TMO_W'(gap + int'($urandom_range(1, 20)));
            f0 = fin_cnt;
            startRun(n);
            if (it == 4) begin
                runImage(n, gap, 1);
                runImage(n, gap, 0);
                checkOutput("rand.cont.finish_count", 32'(fin_cnt - f0), 2);
            end else begin
                runImage(n, gap, 0);
                checkOutput("rand.finish_count", 32'(fin_cnt - f0), 1);
            end
            checkOutput("rand.err", 32'(err), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
